// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped FIFO-buffered 8N1 UART transmitter with status and tohost exit registers
//   clk, rstn               : clock (rising edge), asynchronous active-low reset
//   mem_valid/write/wmask/wdata/addr : data-memory bus request (slave side)
//   mem_rdata, rd_hit       : registered load response, valid the cycle after a load hit
//   tx                      : serial output, idle high
//   exit_valid, exit_code   : sticky tohost-written flag and last value written
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        rd_hit,
  output logic        tx,
  output logic        exit_valid,
  output logic [7:0]  exit_code
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW = FIFO_LOG2 + 1;
  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE = FIFO_LOG2'(1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] fifo [DEPTH];
  logic [FIFO_LOG2-1:0] rptr, wptr;
  logic [CW-1:0] count;
  logic [15:0] baud, baud_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic tx_n, ovf, full, empty, hit, wr, push_req, push, pop, clr, unused_ok;
  logic [31:0] status, rmux;
  assign hit = mem_valid & (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign wr = hit & mem_write & mem_wmask[0];
  assign push_req = wr & (mem_addr[3:2] == 2'd0);
  assign clr = wr & (mem_addr[3:2] == 2'd1) & mem_wdata[3];
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign push = push_req & ~full;
  assign pop = (state == IDLE) & ~empty;
  assign status = (32'(count) << 8) | {28'd0, ovf, empty, full, state != IDLE};
  assign rmux = mem_addr[3:2] == 2'd1 ? status : mem_addr[3:2] == 2'd2 ? {24'd0, exit_code} : '0;
  assign unused_ok = ^{mem_wdata[31:8], mem_addr[1:0], mem_wmask[3:1]};
  always_comb begin
    state_n = state;
    baud_n = baud - 16'd1;
    idx_n = idx;
    shift_n = shift;
    case (state)
      IDLE: begin
        baud_n = RELOAD;
        if (!empty) begin
          state_n = START;
          shift_n = fifo[rptr];
        end
      end
      START: if (baud == '0) begin
        state_n = DATA;
        baud_n = RELOAD;
        idx_n = '0;
      end
      DATA: if (baud == '0) begin
        baud_n = RELOAD;
        shift_n = shift >> 1;
        idx_n = idx + 3'd1;
        if (idx == 3'd7) state_n = STOP;
      end
      STOP: if (baud == '0) begin
        state_n = IDLE;
        baud_n = RELOAD;
      end
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      baud <= RELOAD;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      exit_valid <= 1'b0;
      exit_code <= '0;
      rd_hit <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      idx <= idx_n;
      shift <= shift_n;
      tx <= tx_n;
      if (push) wptr <= wptr + PTR_ONE;
      if (pop) rptr <= rptr + PTR_ONE;
      count <= count + CW'(push) - CW'(pop);
      // a drop in the same cycle as a clear leaves overflow set
      ovf <= (push_req & full) | (ovf & ~clr);
      if (wr && mem_addr[3:2] == 2'd2) begin
        exit_valid <= 1'b1;
        exit_code <= mem_wdata[7:0];
      end
      rd_hit <= hit & ~mem_write;
      mem_rdata <= hit & ~mem_write ? rmux : '0;
    end
  always_ff @(posedge clk) if (push) fifo[wptr] <= mem_wdata[7:0];
endmodule
